mem_stage_pipe: RTL

Parametrised, clocked memory stage for the pipelined Y86-64 core. It sits between the execute/memory pipeline register and write-back, and performs reads and writes on an internal word array with a configurable access latency. It uses a valid/ready handshake on both sides, checks address alignment and range, produces the Y86 status code, and blocks all further memory writes once a non-AOK status has been emitted.

---
 rtl/mem_stage_pipe.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: Y86-64 memory stage with valid/ready handshakes, configurable latency and sticky halt.
module mem_stage_pipe #(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [2:0]        stat_in,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valP,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [2:0]        out_stat,
    output logic [DATA_W-1:0] out_valE,
    output logic [DATA_W-1:0] out_valM,
    output logic [3:0]        out_dstE,
    output logic [3:0]        out_dstM,
    output logic              halted
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, HOLD = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [3:0]        c_icode, c_dste, c_dstm;
    logic [2:0]        c_stat, stat;
    logic [DATA_W-1:0] c_vala, c_vale, c_valp;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] addr, wdata, valm;
    logic [AW-1:0]     idx;
    logic              is_mem, is_rd, is_wr, adr_err, commit, we, take, retire;

    assign in_ready  = state == IDLE || (state == HOLD && out_ready);
    assign out_valid = state == HOLD;
    assign take      = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    always_comb begin
        addr    = (c_icode == 4'h9 || c_icode == 4'hb) ? c_vala : c_vale;
        is_rd   = c_icode == 4'h5 || c_icode == 4'h9 || c_icode == 4'hb;
        is_wr   = c_icode == 4'h4 || c_icode == 4'h8 || c_icode == 4'ha;
        is_mem  = is_rd || is_wr;
        adr_err = addr[2:0] != '0 || (addr >> (AW + 3)) != '0;
        idx     = addr[AW+2:3];
        commit  = state == ACCESS && cnt == '0;
        // an incoming fault wins, then address fault, then the sticky halt
        stat    = c_stat != 3'd1 ? c_stat : (is_mem && adr_err) ? 3'd3 : halted ? 3'd2 : 3'd1;
        valm    = (c_stat == 3'd1 && is_rd && !adr_err) ? mem[idx] : '0;
        we      = commit && c_stat == 3'd1 && is_wr && !adr_err && !halted;
        wdata   = c_icode == 4'h8 ? c_valp : c_vala;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            halted    <= 1'b0;
            c_icode   <= '0;
            c_dste    <= '0;
            c_dstm    <= '0;
            c_stat    <= '0;
            c_vala    <= '0;
            c_vale    <= '0;
            c_valp    <= '0;
            out_icode <= '0;
            out_stat  <= '0;
            out_valE  <= '0;
            out_valM  <= '0;
            out_dstE  <= '0;
            out_dstM  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (retire && out_stat != 3'd1) halted <= 1'b1;
            if (take) begin
                state   <= ACCESS;
                cnt     <= 4'(WAIT_CYCLES);
                c_icode <= icode;
                c_stat  <= stat_in;
                c_dste  <= dstE;
                c_dstm  <= dstM;
                c_vala  <= valA;
                c_vale  <= valE;
                c_valp  <= valP;
            end else if (retire) begin
                state <= IDLE;
            end else if (commit) begin
                state     <= HOLD;
                out_icode <= c_icode;
                out_stat  <= stat;
                out_valE  <= c_vale;
                out_valM  <= valm;
                out_dstE  <= c_dste;
                out_dstM  <= c_dstm;
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
            end
            if (we) mem[idx] <= wdata;
        end
    end
endmodule
